// File: rtl/muldiv_pkg.sv
// Shared encodings and default sizes for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Combinational conditional two's-complement negate used during the FIX cycle.
module muldiv_unit_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO write port.
// Magnitudes are iterated unsigned; signs are restored in a single FIX cycle.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] hi_write_data,
  output logic [DATA_WIDTH-1:0] lo_write_data
);

  localparam int W = DATA_WIDTH;

  state_e             state;
  logic [CNT_WIDTH-1:0] cnt;
  op_e                op_reg;
  logic               sign_a;
  logic               sign_b;
  logic [W-1:0]       opnd_reg;   // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*W-1:0]     acc;        // {hi, lo}: product accumulator or {rem, quot}

  // Operand capture: signed ops iterate on magnitudes
  logic         in_signed;
  logic         in_div;
  logic         in_neg_a;
  logic         in_neg_b;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;

  assign in_signed = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
  assign in_div    = op[1];
  assign in_neg_a  = in_signed & src_a[W-1];
  assign in_neg_b  = in_signed & src_b[W-1];
  assign mag_a     = in_neg_a ? (~src_a + W'(1)) : src_a;
  assign mag_b     = in_neg_b ? (~src_b + W'(1)) : src_b;

  // One iteration step of the shift-add multiplier and the restoring divider
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_sh;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [2*W-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd_reg : '0)};
    mul_next = {mul_sum, acc[W-1:1]};
    rem_sh   = acc[2*W-1:W-1];
    div_ge   = rem_sh >= {1'b0, opnd_reg};
    div_diff = rem_sh[W-1:0] - opnd_reg;
    div_next = {(div_ge ? div_diff : rem_sh[W-1:0]), acc[W-2:0], div_ge};
  end

  // Sign correction: product and quotient follow sign_a^sign_b, remainder follows the dividend
  logic [2*W-1:0] prod_fixed;
  logic [W-1:0]   quot_fixed;
  logic [W-1:0]   rem_fixed;
  logic           is_div;
  logic           div_by_zero;

  assign is_div      = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
  assign div_by_zero = (opnd_reg == '0);

  muldiv_unit_sign_fix #(.WIDTH(2*W)) u_prod_fix (
    .neg    (sign_a ^ sign_b),
    .value  (acc),
    .result (prod_fixed)
  );

  muldiv_unit_sign_fix #(.WIDTH(W)) u_quot_fix (
    .neg    (sign_a ^ sign_b),
    .value  (acc[W-1:0]),
    .result (quot_fixed)
  );

  muldiv_unit_sign_fix #(.WIDTH(W)) u_rem_fix (
    .neg    (sign_a),
    .value  (acc[2*W-1:W]),
    .result (rem_fixed)
  );

  // Main FSM and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op_reg        <= OP_MULT;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      opnd_reg      <= '0;
      acc           <= '0;
      hi_write_data <= '0;
      lo_write_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_reg   <= op_e'(op);
            sign_a   <= in_neg_a;
            sign_b   <= in_neg_b;
            opnd_reg <= in_div ? mag_b : mag_a;
            acc      <= {{W{1'b0}}, (in_div ? mag_a : mag_b)};
            cnt      <= '0;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt == CNT_WIDTH'(W - 1)) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (is_div) begin
              // Divide by zero: quotient is all ones; remainder already equals the dividend
              hi_write_data <= rem_fixed;
              lo_write_data <= div_by_zero ? '1 : quot_fixed;
            end else begin
              hi_write_data <= prod_fixed[2*W-1:W];
              lo_write_data <= prod_fixed[W-1:0];
            end
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign write_en = (state == S_DONE) & ~flush;

endmodule
